lsu_req_ctrl: RTL and testbench
===============================

Name: lsu_req_ctrl

Overview:
- Load/store request controller in the memory stage of the RISC-V core, directly upstream of the load-data mask/extend stage.
- Accepts one load or store op from execute and decodes funct3 and address into a byte-lane mask.
- Checks alignment, drives a word-aligned request to data memory over a valid/ready handshake and waits for the load response.
- Hands the raw word, the lane mask and the unsigned flag downstream, with a one-cycle completion pulse; one op outstanding at a time.

Parameters:
- TIMEOUT, 256, max cycles in RESP before a timeout fault; 0 disables the watchdog (counter 16 bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  op offered by execute
- op_ready  out  1  controller can accept an op
- op_load  in  1  1 = load, 0 = store
- op_funct3  in  3  RISC-V funct3
- op_addr  in  32  effective byte address
- op_wdata  in  32  store data, unshifted, in low bits
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  {op_addr[31:2],2'b00}
- mem_we  out  4  store byte-write enables; 0000 for loads
- mem_wdata  out  32  store data shifted onto lanes
- mem_resp_valid  in  1  load data valid
- mem_resp_data  in  32  load word
- done_valid  out  1  one-cycle completion pulse
- done_fault  out  1  completion is a fault
- done_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout
- ld_raw  out  32  captured load word
- ld_mask  out  4  byte-lane mask for the downstream mask stage
- ld_un  out  1  funct3[2] of the load

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs 0 except op_ready = 1.
  - Timeout counter 0.
  - Any in-flight op is dropped with no done pulse.
- States are IDLE, REQ, RESP and DONE. op_ready = 1 only in IDLE. Accept = op_valid & op_ready.
- Decode (registered at accept):
  - Size is funct3[1:0]: 00 byte, 01 half, 10 word.
  - Byte mask = 0001 << addr[1:0].
  - Half mask = addr[1] ? 1100 : 0011.
  - Word mask = 1111.
  - mem_wdata: byte is wdata[7:0] replicated to all four lanes; half is wdata[15:0] replicated twice; word is wdata.
  - mem_we = mask for stores, 0000 for loads.
- Faults, checked at accept:
  - Illegal funct3 (cause 2): funct3 of 011, 110 or 111, or a store with funct3[2] = 1.
  - Misaligned (cause 1): half with addr[0] = 1, or word with addr[1:0] != 00.
  - Illegal funct3 takes priority over misaligned.
  - A faulting op goes IDLE->DONE, issues no memory request, and presents ld_mask = 0000.
- IDLE->REQ on a non-faulting accept. mem_req_valid rises the next cycle.
- REQ:
  - mem_req_valid, mem_addr, mem_we and mem_wdata are held stable until mem_req_ready.
  - On handshake, a store goes to DONE and a load goes to RESP.
- RESP:
  - The counter increments each cycle.
  - If mem_resp_valid, capture mem_resp_data into ld_raw and go to DONE.
  - Else, if TIMEOUT != 0 and the counter reaches TIMEOUT-1, go to DONE with fault cause 3.
  - The counter clears on leaving RESP.
- DONE (exactly one cycle):
  - done_valid = 1, with done_fault/done_cause set.
  - ld_raw, ld_mask and ld_un are valid and held until the next accept.
  - Next state is IDLE.
- mem_resp_valid outside RESP is ignored.
- Latency with zero-wait memory, counted from the accept cycle 0:
  - Store: mem_req_valid in cycle 1, done in cycle 2.
  - Load: request in cycle 1, response in cycle 2, done in cycle 3.
  - Fault: done in cycle 1.
- Back-to-back: a new accept is possible in the cycle after DONE.

Test Plan:
- SB, addr 0x1003, wdata 0x000000A5, mem_req_ready = 1 -> cycle 1 shows mem_addr 0x1000, mem_we 1000, mem_wdata 0xA5A5A5A5; done_valid in cycle 2 with cause 0.
- LHU, addr 0x2002, memory returns 0xBEEF1234 one cycle after handshake -> done in cycle 3 with ld_raw 0xBEEF1234, ld_mask 1100, ld_un 1.
- LW, addr 0x3001 -> no mem_req_valid; done_valid in cycle 1 with fault 1, cause 1.
- Store with funct3 100 -> done with fault, cause 2. A load with funct3 011 at a misaligned address also gives cause 2.
- SW with mem_req_ready held low for 5 cycles -> mem_req_valid, mem_addr, mem_we 1111 and mem_wdata stay stable throughout; done arrives the cycle after ready rises.
- TIMEOUT = 4, LB with no response -> done with cause 3 after 4 cycles in RESP.
- Reset pulsed in RESP -> back in IDLE, op_ready = 1, no done pulse; a late mem_resp_valid is ignored.

Source files
------------

// File: rtl/lsu_req_ctrl.sv
// Memory-stage load/store request controller: decodes one op into a lane mask,
// issues a word-aligned request, waits for load data and reports completion.
module lsu_req_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_load,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        done_valid,
  output logic        done_fault,
  output logic [1:0]  done_cause,
  output logic [31:0] ld_raw,
  output logic [3:0]  ld_mask,
  output logic        ld_un
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [1:0]  C_NONE = 2'd0, C_MISAL = 2'd1, C_ILL = 2'd2, C_TMO = 2'd3;
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, raw_q, raw_d;
  logic [3:0]  we_q, we_d, mask_q, mask_d;
  logic        un_q, un_d, load_q, load_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] cnt_q, cnt_d;

  logic [3:0]  dec_mask;
  logic [31:0] dec_wdata;
  logic        illegal, misal;

  // Sub-word stores replicate the data on every lane so the write enables alone pick the bytes.
  always_comb begin
    dec_mask  = 4'b0000;
    dec_wdata = op_wdata;
    case (op_funct3[1:0])
      2'b00: begin
        dec_mask  = 4'b0001 << op_addr[1:0];
        dec_wdata = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        dec_mask  = op_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{op_wdata[15:0]}};
      end
      2'b10:   dec_mask = 4'b1111;
      default: dec_mask = 4'b0000;
    endcase
  end

  assign illegal = (op_funct3[1:0] == 2'b11) || (op_funct3[2] && (op_funct3[1] || !op_load));
  assign misal   = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                   ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raw_d   = raw_q;
    we_d    = we_q;
    mask_d  = mask_q;
    un_d    = un_q;
    load_d  = load_q;
    cause_d = cause_q;
    cnt_d   = 16'd0;
    case (state_q)
      IDLE: if (op_valid) begin
        addr_d = {op_addr[31:2], 2'b00};
        load_d = op_load;
        un_d   = op_load & op_funct3[2];
        raw_d  = 32'd0;
        if (illegal || misal) begin
          cause_d = illegal ? C_ILL : C_MISAL;
          mask_d  = 4'b0000;
          we_d    = 4'b0000;
          state_d = DONE;
        end else begin
          cause_d = C_NONE;
          mask_d  = dec_mask;
          we_d    = op_load ? 4'b0000 : dec_mask;
          wdata_d = dec_wdata;
          state_d = REQ;
        end
      end
      REQ: if (mem_req_ready) state_d = load_q ? RESP : DONE;
      RESP: begin
        if (mem_resp_valid) begin
          raw_d   = mem_resp_data;
          state_d = DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          cause_d = C_TMO;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
      we_q    <= '0;
      mask_q  <= '0;
      un_q    <= 1'b0;
      load_q  <= 1'b0;
      cause_q <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raw_q   <= raw_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      un_q    <= un_d;
      load_q  <= load_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign done_valid    = (state_q == DONE);
  assign done_cause    = done_valid ? cause_q : C_NONE;
  assign done_fault    = done_valid && (cause_q != C_NONE);
  assign ld_raw        = raw_q;
  assign ld_mask       = mask_q;
  assign ld_un         = un_q;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Bench for lsu_req_ctrl: fixed vectors, hand-written corner sequences and
// randomized ops checked against a byte-level reference model.
module tb_lsu_req_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        op_valid = 1'b0, op_ready, op_load = 1'b0;
  logic [2:0]  op_funct3 = '0;
  logic [31:0] op_addr = '0, op_wdata = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        done_valid, done_fault, ld_un;
  logic [1:0]  done_cause;
  logic [31:0] ld_raw;
  logic [3:0]  ld_mask;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  lsu_req_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_load(op_load),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .done_valid(done_valid), .done_fault(done_fault), .done_cause(done_cause),
    .ld_raw(ld_raw), .ld_mask(ld_mask), .ld_un(ld_un)
  );

  typedef struct packed {
    logic        load;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  rd, rsd;      // ready delay after request; response delay after entering RESP
    logic        fault;
    logic [1:0]  cause;
    logic [3:0]  mask, we;
    logic [31:0] mwdata;
    logic [7:0]  dcyc;         // done cycle, accept = cycle 0
    logic        un;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic load, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int rd, int rsd, logic fault, logic [1:0] cause,
                              logic [3:0] mask, logic [3:0] we, logic [31:0] mwdata, int dcyc, logic un);
    vec_t v;
    v.load = load; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rd = 8'(rd); v.rsd = 8'(rsd); v.fault = fault; v.cause = cause; v.mask = mask;
    v.we = we; v.mwdata = mwdata; v.dcyc = 8'(dcyc); v.un = un;
    return v;
  endfunction

  // Reference: access of n bytes must sit on an n-byte boundary; data lanes repeat every n bytes.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int n = 1 << v.f3[1:0];
    int off = int'(v.addr[1:0]);
    int h = 1 + int'(v.rd);
    bit ill = (v.f3[1:0] == 2'b11) || (v.f3[2] && (!v.load || n == 4));
    bit mis = (off % n) != 0;
    r.fault = ill || mis;
    r.cause = ill ? 2'd2 : (mis ? 2'd1 : 2'd0);
    r.mask  = r.fault ? 4'd0 : 4'(((1 << n) - 1) << off);
    r.we    = v.load ? 4'd0 : r.mask;
    for (int i = 0; i < 4; i++) r.mwdata[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    r.un = v.f3[2];
    if (r.fault)                 r.dcyc = 8'd1;
    else if (!v.load)            r.dcyc = 8'(h + 1);
    else if (int'(v.rsd) < T)    r.dcyc = 8'(h + 2 + int'(v.rsd));
    else begin
      r.dcyc  = 8'(h + 1 + T);
      r.fault = 1'b1;
      r.cause = 2'd3;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int dc = -1, nreq = 0, h = 1 + int'(v.rd);
    bit stab = 1'b1;
    logic df = 1'b0, un = 1'b0;
    logic [1:0] dcause = '0;
    logic [31:0] raw = '0;
    logic [3:0] msk = '0;
    @(negedge clk);
    chk({nm, ":op_ready"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_load = v.load; op_funct3 = v.f3; op_addr = v.addr; op_wdata = v.wdata;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_load = 1'($urandom); op_funct3 = 3'($urandom);
    op_addr = $urandom; op_wdata = $urandom;
    for (int c = 1; c < 64 && dc < 0; c++) begin
      @(negedge clk);
      mem_req_ready  = (c >= h);
      mem_resp_valid = v.load && (c == h + 1 + int'(v.rsd));
      mem_resp_data  = mem_resp_valid ? v.rdata : $urandom;
      if (mem_req_valid) begin
        nreq++;
        if (mem_addr !== {v.addr[31:2], 2'b00} || mem_we !== v.we ||
            (!v.load && mem_wdata !== v.mwdata)) stab = 1'b0;
      end
      if (done_valid) begin
        dc = c; df = done_fault; dcause = done_cause; raw = ld_raw; msk = ld_mask; un = ld_un;
      end
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk({nm, ":done_cycle"}, 32'(dc), 32'(v.dcyc));
    chk({nm, ":fault"}, 32'(df), 32'(v.fault));
    chk({nm, ":cause"}, 32'(dcause), 32'(v.cause));
    chk({nm, ":req_cycles"}, 32'(nreq), (v.fault && v.cause != 2'd3) ? 32'd0 : 32'(1 + v.rd));
    chk({nm, ":req_stable"}, 32'(stab), 32'd1);
    if (v.cause != 2'd3) chk({nm, ":ld_mask"}, 32'(msk), 32'(v.mask));
    if (v.load && !v.fault) begin
      chk({nm, ":ld_raw"}, raw, v.rdata);
      chk({nm, ":ld_un"}, 32'(un), 32'(v.un));
    end
  endtask

  vec_t tbl[12];

  initial begin
    int pulses;
    tbl[0]  = mk(0, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0, 0, 2'd0, 4'b1000, 4'b1000, 32'hA5A5A5A5, 2, 0);
    tbl[1]  = mk(1, 3'b101, 32'h2002, 0, 32'hBEEF1234, 0, 0, 0, 2'd0, 4'b1100, 4'b0000, 0, 3, 1);
    tbl[2]  = mk(1, 3'b010, 32'h3001, 0, 0, 0, 0, 1, 2'd1, 4'b0000, 4'b0000, 0, 1, 0);
    tbl[3]  = mk(0, 3'b100, 32'h4000, 32'h11, 0, 0, 0, 1, 2'd2, 4'b0000, 4'b0000, 0, 1, 0);
    tbl[4]  = mk(1, 3'b011, 32'h4001, 0, 0, 0, 0, 1, 2'd2, 4'b0000, 4'b0000, 0, 1, 0);
    tbl[5]  = mk(0, 3'b010, 32'h5004, 32'h12345678, 0, 5, 0, 0, 2'd0, 4'b1111, 4'b1111, 32'h12345678, 7, 0);
    tbl[6]  = mk(1, 3'b000, 32'h6001, 0, 0, 0, 99, 1, 2'd3, 4'b0010, 4'b0000, 0, 6, 0);
    tbl[7]  = mk(0, 3'b001, 32'h7002, 32'h0000BEEF, 0, 2, 0, 0, 2'd0, 4'b1100, 4'b1100, 32'hBEEFBEEF, 4, 0);
    tbl[8]  = mk(1, 3'b001, 32'h7001, 0, 0, 0, 0, 1, 2'd1, 4'b0000, 4'b0000, 0, 1, 0);
    tbl[9]  = mk(1, 3'b100, 32'h8002, 0, 32'hCAFEF00D, 1, 3, 0, 2'd0, 4'b0100, 4'b0000, 0, 7, 1);
    tbl[10] = mk(1, 3'b010, 32'h9000, 0, 32'h0BADF00D, 0, 3, 0, 2'd0, 4'b1111, 4'b0000, 0, 6, 0);
    tbl[11] = mk(0, 3'b000, 32'h0010, 32'h1234567F, 0, 0, 0, 0, 2'd0, 4'b0001, 4'b0001, 32'h7F7F7F7F, 2, 0);

    // Reset state
    #12;
    chk("rst:op_ready", 32'(op_ready), 32'd1);
    chk("rst:req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst:done_valid", 32'(done_valid), 32'd0);
    chk("rst:mem_we", 32'(mem_we), 32'd0);
    chk("rst:ld_raw", ld_raw, 32'd0);
    chk("rst:ld_mask", 32'(ld_mask), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Completed load results stay put while idle; stray responses outside RESP are ignored.
    run_vec(tbl[1], "hold");
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_resp_data = $urandom;
      if (done_valid) pulses++;
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("hold:pulses", 32'(pulses), 32'd0);
    chk("hold:ld_raw", ld_raw, 32'hBEEF1234);
    chk("hold:ld_mask", 32'(ld_mask), 32'b1100);
    chk("hold:ld_un", 32'(ld_un), 32'd1);

    // Reset while waiting in RESP drops the op silently.
    @(negedge clk);
    op_valid = 1'b1; op_load = 1'b1; op_funct3 = 3'b010; op_addr = 32'h20;
    @(posedge clk);
    #1 op_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstresp:op_ready", 32'(op_ready), 32'd1);
    chk("rstresp:done_valid", 32'(done_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_valid) pulses++;
    end
    mem_resp_valid = 1'b0;
    chk("rstresp:pulses", 32'(pulses), 32'd0);
    chk("rstresp:ld_raw", ld_raw, 32'd0);
    chk("rstresp:op_ready", 32'(op_ready), 32'd1);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      vec_t v;
      v = mk(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 5), 0, 0, 0, 0, 0, 0, 0);
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
